writeback_regfile: RTL and testbench

- Producer end of the decode-stage operand forwarding path for the 5-stage Y86-64 pipeline.
- Holds the W pipeline register, which is captured from the M stage.
- Performs the architectural register-file writes from W and supplies the raw register read values d_rvalA/d_rvalB to the decode-stage forwarding muxes.
- Exposes W_dstE/W_dstM/W_valE/W_valM as the lowest-priority forwarding sources, and W_stat as the processor status.

---
 rtl/writeback_regfile.sv | 108 ++++++++++
 tb/tb_writeback_regfile.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/writeback_regfile.sv
// writeback_regfile: W pipeline register plus the architectural register file
// of the 5-stage Y86-64 pipeline. W is captured from M each cycle (subject to
// stall/bubble), retires into the register file one edge later, and the file
// is read combinationally by decode (ports A/B) and by a debug port.
//
// Handshake note: this block has no valid/ready handshake. W_stall and
// W_bubble come from the pipeline control logic; stall has priority over
// bubble, and a held instruction keeps rewriting the same value, which is
// harmless.
module writeback_regfile #(
  parameter int XLEN = 64,
  parameter int NREG = 15
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            W_stall,
  input  logic            W_bubble,
  input  logic [2:0]      M_stat,
  input  logic [3:0]      M_icode,
  input  logic [XLEN-1:0] M_valE,
  input  logic [XLEN-1:0] m_valM,
  input  logic [3:0]      M_dstE,
  input  logic [3:0]      M_dstM,
  input  logic [3:0]      d_srcA,
  input  logic [3:0]      d_srcB,
  input  logic [3:0]      dbg_addr,
  output logic [2:0]      W_stat,
  output logic [3:0]      W_icode,
  output logic [XLEN-1:0] W_valE,
  output logic [XLEN-1:0] W_valM,
  output logic [3:0]      W_dstE,
  output logic [3:0]      W_dstM,
  output logic [XLEN-1:0] d_rvalA,
  output logic [XLEN-1:0] d_rvalB,
  output logic [XLEN-1:0] dbg_data
);

  localparam logic [2:0] STAT_AOK = 3'd1;
  localparam logic [3:0] INOP     = 4'h1;
  localparam logic [3:0] RNONE    = 4'hF;

  logic [XLEN-1:0] regs [NREG];

  // Read one register; ids outside 0..NREG-1 (notably RNONE) return zero.
  function automatic logic [XLEN-1:0] rd(input logic [3:0] id);
    logic [XLEN-1:0] v;
    v = '0;
    for (int i = 0; i < NREG; i++) begin
      if (id == 4'(i)) v = regs[i];
    end
    return v;
  endfunction

  // W pipeline register: stall holds, bubble loads a NOP, otherwise capture M.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      W_stat  <= STAT_AOK;
      W_icode <= INOP;
      W_valE  <= '0;
      W_valM  <= '0;
      W_dstE  <= RNONE;
      W_dstM  <= RNONE;
    end else if (W_stall) begin
      W_stat  <= W_stat;
      W_icode <= W_icode;
      W_valE  <= W_valE;
      W_valM  <= W_valM;
      W_dstE  <= W_dstE;
      W_dstM  <= W_dstM;
    end else if (W_bubble) begin
      W_stat  <= STAT_AOK;
      W_icode <= INOP;
      W_valE  <= '0;
      W_valM  <= '0;
      W_dstE  <= RNONE;
      W_dstM  <= RNONE;
    end else begin
      W_stat  <= M_stat;
      W_icode <= M_icode;
      W_valE  <= M_valE;
      W_valM  <= m_valM;
      W_dstE  <= M_dstE;
      W_dstM  <= M_dstM;
    end
  end

  // Architectural write from the current W contents; M port beats E port
  // when both name the same register (popq %rsp). Only AOK instructions retire.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (W_stat == STAT_AOK) begin
      for (int i = 0; i < NREG; i++) begin
        if (W_dstM == 4'(i))      regs[i] <= W_valM;
        else if (W_dstE == 4'(i)) regs[i] <= W_valE;
      end
    end
  end

  // Combinational reads with no write-through; same-cycle values come from
  // the external forwarding muxes via W_dstE/W_dstM.
  always_comb begin
    d_rvalA  = rd(d_srcA);
    d_rvalB  = rd(d_srcB);
    dbg_data = rd(dbg_addr);
  end

endmodule

// File: tb/tb_writeback_regfile.sv
// tb_writeback_regfile: directed scenarios followed by random traffic,
// compared against a behavioural model of the W register and register file.
module tb_writeback_regfile;

  localparam int XLEN = 64;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic            W_stall, W_bubble;
  logic [2:0]      M_stat;
  logic [3:0]      M_icode, M_dstE, M_dstM, d_srcA, d_srcB, dbg_addr;
  logic [XLEN-1:0] M_valE, m_valM;
  logic [2:0]      W_stat;
  logic [3:0]      W_icode, W_dstE, W_dstM;
  logic [XLEN-1:0] W_valE, W_valM, d_rvalA, d_rvalB, dbg_data;

  writeback_regfile #(.XLEN(XLEN), .NREG(15)) dut (
    .clk(clk), .rst_n(rst_n), .W_stall(W_stall), .W_bubble(W_bubble),
    .M_stat(M_stat), .M_icode(M_icode), .M_valE(M_valE), .m_valM(m_valM),
    .M_dstE(M_dstE), .M_dstM(M_dstM), .d_srcA(d_srcA), .d_srcB(d_srcB),
    .dbg_addr(dbg_addr), .W_stat(W_stat), .W_icode(W_icode),
    .W_valE(W_valE), .W_valM(W_valM), .W_dstE(W_dstE), .W_dstM(W_dstM),
    .d_rvalA(d_rvalA), .d_rvalB(d_rvalB), .dbg_data(dbg_data)
  );

  // ---------------- reference model ----------------
  typedef struct {
    logic [2:0]      stat;
    logic [3:0]      icode;
    logic [XLEN-1:0] val_e;
    logic [XLEN-1:0] val_m;
    logic [3:0]      dst_e;
    logic [3:0]      dst_m;
  } w_t;

  typedef struct {
    w_t              w;
    logic [XLEN-1:0] rval_a;
    logic [XLEN-1:0] rval_b;
    logic [XLEN-1:0] dbg;
  } exp_t;

  w_t              m_w;
  logic [XLEN-1:0] m_regs [15];
  exp_t            exp_q [$];

  int checks = 0;
  int failures = 0;

  function automatic w_t nop_w();
    w_t w;
    w.stat = 3'd1; w.icode = 4'h1; w.val_e = '0; w.val_m = '0;
    w.dst_e = 4'hF; w.dst_m = 4'hF;
    return w;
  endfunction

  function automatic logic [XLEN-1:0] model_rd(input logic [3:0] id);
    if (id == 4'hF) return '0;
    return m_regs[id];
  endfunction

  task automatic model_reset();
    m_w = nop_w();
    for (int i = 0; i < 15; i++) m_regs[i] = '0;
  endtask

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [XLEN-1:0] act,
                       input logic [XLEN-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: the DUT presents a fresh W/read state after every edge; compare
  // each queued expectation at the following falling edge.
  always @(negedge clk) begin
    if (rst_n) begin
      while (exp_q.size() > 0) begin
        exp_t e;
        e = exp_q.pop_front();
        check("W_stat",   {61'd0, W_stat},  {61'd0, e.w.stat});
        check("W_icode",  {60'd0, W_icode}, {60'd0, e.w.icode});
        check("W_valE",   W_valE,           e.w.val_e);
        check("W_valM",   W_valM,           e.w.val_m);
        check("W_dstE",   {60'd0, W_dstE},  {60'd0, e.w.dst_e});
        check("W_dstM",   {60'd0, W_dstM},  {60'd0, e.w.dst_m});
        check("d_rvalA",  d_rvalA,          e.rval_a);
        check("d_rvalB",  d_rvalB,          e.rval_b);
        check("dbg_data", dbg_data,         e.dbg);
      end
    end
  end

  // Control logic must never assert stall and bubble together.
  always @(posedge clk) begin
    if (rst_n && W_stall && W_bubble)
      $display("FAIL illegal_ctrl stall=1 bubble=1 at %0t", $time);
  end

  // ---------------- driver ----------------
  // One cycle: drive inputs after a falling edge, then at the rising edge
  // advance the model (retire old W, then load new W) and queue the result.
  task automatic step(input logic [2:0] stat, input logic [3:0] icode,
                      input logic [XLEN-1:0] val_e, input logic [XLEN-1:0] val_m,
                      input logic [3:0] dst_e, input logic [3:0] dst_m,
                      input logic stall, input logic bubble,
                      input logic [3:0] src_a, input logic [3:0] src_b,
                      input logic [3:0] dbg_id);
    exp_t e;
    @(negedge clk); #1;
    M_stat = stat; M_icode = icode; M_valE = val_e; m_valM = val_m;
    M_dstE = dst_e; M_dstM = dst_m; W_stall = stall; W_bubble = bubble;
    d_srcA = src_a; d_srcB = src_b; dbg_addr = dbg_id;
    @(posedge clk);
    if (m_w.stat == 3'd1) begin
      if (m_w.dst_e != 4'hF) m_regs[m_w.dst_e] = m_w.val_e;
      if (m_w.dst_m != 4'hF) m_regs[m_w.dst_m] = m_w.val_m;
    end
    if (stall) begin
      // W holds
    end else if (bubble) begin
      m_w = nop_w();
    end else begin
      m_w.stat = stat; m_w.icode = icode; m_w.val_e = val_e; m_w.val_m = val_m;
      m_w.dst_e = dst_e; m_w.dst_m = dst_m;
    end
    e.w = m_w;
    e.rval_a = model_rd(src_a);
    e.rval_b = model_rd(src_b);
    e.dbg = model_rd(dbg_id);
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n, input logic [3:0] src_a,
                      input logic [3:0] src_b, input logic [3:0] dbg_id);
    for (int k = 0; k < n; k++)
      step(3'd1, 4'h1, '0, '0, 4'hF, 4'hF, 1'b0, 1'b0, src_a, src_b, dbg_id);
  endtask

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  // ---------------- stimulus ----------------
  initial begin
    W_stall = 0; W_bubble = 0; M_stat = 3'd1; M_icode = 4'h1;
    M_valE = '0; m_valM = '0; M_dstE = 4'hF; M_dstM = 4'hF;
    d_srcA = 4'h0; d_srcB = 4'hF; dbg_addr = 4'h0;
    model_reset();

    // Reset state, with every register visible as zero.
    #12;
    check("rst_W_stat",  {61'd0, W_stat},  64'd1);
    check("rst_W_icode", {60'd0, W_icode}, 64'd1);
    check("rst_W_dstE",  {60'd0, W_dstE},  64'hF);
    check("rst_W_dstM",  {60'd0, W_dstM},  64'hF);
    for (int i = 0; i < 15; i++) begin
      d_srcA = 4'(i); #1;
      check("rst_rvalA", d_rvalA, 64'd0);
    end
    @(negedge clk); #1 rst_n = 1'b1;

    // No spurious writes after release.
    idle(2, 4'h0, 4'h7, 4'hE);

    // Simple E-port write, visible two edges after presentation.
    step(3'd1, 4'h6, 64'h1234, '0, 4'h3, 4'hF, 1'b0, 1'b0, 4'h3, 4'hF, 4'h3);
    idle(2, 4'h3, 4'hF, 4'h3);

    // popq %rsp: M port wins on a shared destination.
    step(3'd1, 4'hB, 64'h100, 64'h200, 4'h4, 4'h4, 1'b0, 1'b0, 4'h4, 4'h3, 4'h4);
    idle(2, 4'h4, 4'hF, 4'h4);

    // Bubble discards the M-stage instruction.
    step(3'd1, 4'h6, 64'hFF, '0, 4'h5, 4'hF, 1'b0, 1'b1, 4'h5, 4'hF, 4'h5);
    idle(1, 4'h5, 4'hF, 4'h5);
    // Load an instruction, then stall three cycles while M keeps changing.
    step(3'd1, 4'h2, 64'hABC, 64'h0, 4'h6, 4'hF, 1'b0, 1'b0, 4'h6, 4'h5, 4'h6);
    for (int k = 0; k < 3; k++)
      step(3'd1, 4'h6, 64'(k + 100), 64'(k + 200), 4'h8, 4'h9,
           1'b1, 1'b0, 4'h8, 4'h9, 4'h6);
    idle(2, 4'h6, 4'h8, 4'h9);

    // ADR status blocks writes; control holds W so status persists.
    step(3'd3, 4'h5, 64'h0, 64'hDEAD, 4'hF, 4'h2, 1'b0, 1'b0, 4'h2, 4'hF, 4'h2);
    for (int k = 0; k < 4; k++)
      step(3'd1, 4'h1, '0, '0, 4'hF, 4'hF, 1'b1, 1'b0, 4'h2, 4'hF, 4'h2);
    step(3'd1, 4'h1, '0, '0, 4'hF, 4'hF, 1'b0, 1'b1, 4'h2, 4'hF, 4'h2);
    idle(1, 4'h2, 4'hF, 4'h2);

    // reg7 = 0x77, then an asynchronous reset between edges.
    step(3'd1, 4'h3, 64'h77, '0, 4'h7, 4'hF, 1'b0, 1'b0, 4'h7, 4'hF, 4'h7);
    idle(2, 4'h7, 4'hF, 4'h7);
    @(negedge clk); #3;
    check("pre_async_dbg7", dbg_data, 64'h77);
    rst_n = 1'b0; #1;
    model_reset();
    check("async_dbg7",    dbg_data, 64'd0);
    check("async_rvalB_F", d_rvalB,  64'd0);
    check("async_W_stat",  {61'd0, W_stat}, 64'd1);
    check("async_W_dstE",  {60'd0, W_dstE}, 64'hF);
    repeat (2) @(posedge clk);
    @(negedge clk); #1 rst_n = 1'b1;
    idle(1, 4'h7, 4'hF, 4'h7);

    // Random traffic.
    for (int n = 0; n < 400; n++) begin
      logic [2:0] st;
      logic       stl, bub;
      int         r;
      st = ($urandom_range(0, 19) == 0) ? 3'($urandom_range(2, 4)) : 3'd1;
      r = $urandom_range(0, 9);
      stl = (r == 0);
      bub = (r == 1);
      step(st, 4'($urandom_range(0, 11)),
           {$urandom, $urandom}, {$urandom, $urandom},
           ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom_range(0, 14)),
           ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 14)) : 4'hF,
           stl, bub,
           4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
           4'($urandom_range(0, 15)));
    end

    @(negedge clk); #1;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain actual=%0d expected=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
